// File: rtl/if_fetch_unit.sv
// MIPS instruction-fetch stage: PC register, IF/ID register, jump/branch redirect, stall and bubble insertion.
// Optional IF_PERF_CNT_EN adds saturating fetched/bubble counters.
module if_fetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  id_pc_src,
    input  logic [31:0] id_jr_target,
    input  logic        ex_branch_taken,
    input  logic [31:0] ex_branch_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        flush_id_ex
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_bubbles
`endif
);

    typedef enum logic [2:0] {
        ACT_SEQ,
        ACT_BRANCH,
        ACT_STALL,
        ACT_JUMP,
        ACT_JR
    } act_t;

    act_t        act;
    logic [31:0] pc_plus4;
    logic [31:0] jump_target;
    logic [31:0] redirect_pc;
    logic        unused_bits;

    assign imem_addr   = pc;
    assign pc_plus4    = pc + 32'd4;
    assign jump_target = {if_id_pc_plus4[31:28], if_id_instr[25:0], 2'b00};
    assign unused_bits = ^{id_jr_target[1:0], ex_branch_target[1:0]};

    // A bubble in ID never redirects, so the decoder's PCSrc is qualified by valid.
    always_comb begin
        act         = ACT_SEQ;
        redirect_pc = pc_plus4;
        if (ex_branch_taken) begin
            act         = ACT_BRANCH;
            redirect_pc = {ex_branch_target[31:2], 2'b00};
        end else if (stall) begin
            act = ACT_STALL;
        end else if (if_id_valid && id_pc_src == 2'b01) begin
            act         = ACT_JUMP;
            redirect_pc = jump_target;
        end else if (if_id_valid && id_pc_src == 2'b11) begin
            act         = ACT_JR;
            redirect_pc = {id_jr_target[31:2], 2'b00};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc             <= PC_RESET;
            if_id_instr    <= NOP_WORD;
            if_id_pc_plus4 <= 32'd0;
            if_id_valid    <= 1'b0;
            flush_id_ex    <= 1'b0;
        end else begin
            flush_id_ex <= (act == ACT_BRANCH);
            case (act)
                ACT_STALL: ;
                ACT_SEQ: begin
                    pc             <= pc_plus4;
                    if_id_instr    <= imem_rdata;
                    if_id_pc_plus4 <= pc_plus4;
                    if_id_valid    <= 1'b1;
                end
                default: begin
                    pc             <= redirect_pc;
                    if_id_instr    <= NOP_WORD;
                    if_id_pc_plus4 <= 32'd0;
                    if_id_valid    <= 1'b0;
                end
            endcase
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched <= 32'd0;
            perf_bubbles <= 32'd0;
        end else if (act == ACT_SEQ) begin
            if (perf_fetched != 32'hFFFF_FFFF) perf_fetched <= perf_fetched + 32'd1;
        end else if (act != ACT_STALL) begin
            if (perf_bubbles != 32'hFFFF_FFFF) perf_bubbles <= perf_bubbles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: directed scenarios then randomized traffic against a behavioural model.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic [1:0]  id_pc_src = 2'b00;
    logic [31:0] id_jr_target = 32'd0;
    logic        ex_branch_taken = 1'b0;
    logic [31:0] ex_branch_target = 32'd0;
    logic [31:0] imem_addr, imem_rdata, pc, if_id_instr, if_id_pc_plus4;
    logic        if_id_valid, flush_id_ex;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_bubbles;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .id_pc_src(id_pc_src),
        .id_jr_target(id_jr_target), .ex_branch_taken(ex_branch_taken),
        .ex_branch_target(ex_branch_target), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .pc(pc), .if_id_instr(if_id_instr),
        .if_id_pc_plus4(if_id_pc_plus4), .if_id_valid(if_id_valid),
        .flush_id_ex(flush_id_ex)
`ifdef IF_PERF_CNT_EN
        , .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles)
`endif
    );

    // Instruction memory contents: a couple of fixed words, pseudo-random elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h2008_0005;
        if (a == 32'h4) return 32'h0800_0040;
        return (a * 32'h9E37_79B1) ^ 32'hA5C3_0F17;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    typedef struct {
        logic [31:0] pc, instr, pp4;
        logic        valid, flush;
        longint      fetched, bubbles;
    } st_t;

    st_t m;
    st_t expq[$];

    // Architectural view: what the stage does this cycle, then the resulting visible state.
    task automatic step(input logic rst, input logic st, input logic [1:0] src,
                        input logic [31:0] jr, input logic bt, input logic [31:0] btgt);
        st_t n;
        logic redirect;
        logic [31:0] tgt;
        @(negedge clk);
        reset = rst; stall = st; id_pc_src = src; id_jr_target = jr;
        ex_branch_taken = bt; ex_branch_target = btgt;
        n = m;
        n.flush = 1'b0;
        redirect = 1'b0;
        tgt = 32'd0;
        if (rst) begin
            n = '{pc: 32'h0, instr: 32'h0, pp4: 32'h0, valid: 1'b0, flush: 1'b0, fetched: 0, bubbles: 0};
        end else begin
            if (bt) begin
                redirect = 1'b1; tgt = btgt & ~32'd3; n.flush = 1'b1;
            end else if (st) begin
                redirect = 1'b0;
            end else if (m.valid && src == 2'b01) begin
                redirect = 1'b1; tgt = {m.pp4[31:28], 28'd0} + ((m.instr & 32'h03FF_FFFF) * 4);
            end else if (m.valid && src == 2'b11) begin
                redirect = 1'b1; tgt = jr & ~32'd3;
            end
            if (redirect) begin
                n.pc = tgt; n.instr = 32'h0; n.pp4 = 32'h0; n.valid = 1'b0;
                n.bubbles = m.bubbles + 1;
            end else if (!st) begin
                n.instr = mem_word(m.pc); n.pc = m.pc + 32'd4; n.pp4 = n.pc; n.valid = 1'b1;
                n.fetched = m.fetched + 1;
            end
            if (n.fetched > 64'hFFFF_FFFF) n.fetched = 64'hFFFF_FFFF;
            if (n.bubbles > 64'hFFFF_FFFF) n.bubbles = 64'hFFFF_FFFF;
        end
        m = n;
        expq.push_back(n);
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every edge that has a pending expectation is checked just after it.
    initial begin
        st_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                cmp("pc", pc, e.pc);
                cmp("imem_addr", imem_addr, e.pc);
                cmp("if_id_instr", if_id_instr, e.instr);
                cmp("if_id_pc_plus4", if_id_pc_plus4, e.pp4);
                cmp("if_id_valid", {31'd0, if_id_valid}, {31'd0, e.valid});
                cmp("flush_id_ex", {31'd0, flush_id_ex}, {31'd0, e.flush});
`ifdef IF_PERF_CNT_EN
                cmp("perf_fetched", perf_fetched, e.fetched[31:0]);
                cmp("perf_bubbles", perf_bubbles, e.bubbles[31:0]);
`endif
            end
        end
    end

    initial begin
        m = '{pc: 32'h0, instr: 32'h0, pp4: 32'h0, valid: 1'b0, flush: 1'b0, fetched: 0, bubbles: 0};
        // Reset overrides a simultaneous branch and stall.
        step(1, 1, 2'b01, 32'h0, 1, 32'h80);
        step(1, 0, 2'b00, 32'h0, 0, 32'h0);
        // Sequential from 0: pc 4, 8 with words from 0 and 4 in IF/ID.
        step(0, 0, 2'b00, 32'h0, 0, 32'h0);
        step(0, 0, 2'b00, 32'h0, 0, 32'h0);
        // Stall for three cycles with a pending jump in ID; the jump waits.
        repeat (3) step(0, 1, 2'b01, 32'h0, 0, 32'h0);
        // j 0x100 now resolves, then a bubble in ID ignores PCSrc.
        step(0, 0, 2'b01, 32'h0, 0, 32'h0);
        step(0, 0, 2'b01, 32'h0, 0, 32'h0);
        // Taken branch beats both stall and jump; target alignment enforced.
        step(0, 1, 2'b01, 32'h0, 1, 32'h43);
        step(0, 0, 2'b00, 32'h0, 0, 32'h0);
        // jr to 0x203 -> 0x200; reserved PCSrc 10 is sequential.
        step(0, 0, 2'b11, 32'h203, 0, 32'h0);
        step(0, 0, 2'b10, 32'h0, 0, 32'h0);
        // jr to top of memory, then wrap to 0.
        step(0, 0, 2'b11, 32'hFFFF_FFFF, 0, 32'h0);
        step(0, 0, 2'b00, 32'h0, 0, 32'h0);
        step(0, 0, 2'b00, 32'h0, 0, 32'h0);
        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 4) == 0),
                 2'($urandom_range(0, 3)), $urandom, ($urandom_range(0, 7) == 0), $urandom);
        end
        for (int i = 0; i < 10 && expq.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", expq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
